// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: region decode, wait states, byte lanes,
// alignment checks and a valid/ready request/response handshake.
module mem_bus_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int CS_W = 2,
  parameter logic [4*(2**CS_W)-1:0] WAIT_CYCLES =
    {4'd2, 4'd1, 4'd0, 4'd0},
  parameter logic [(2**CS_W)-1:0] REGION_EN = 4'b1110
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [CS_W-1:0]               req_cs,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [1:0]                    req_size,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [(2**CS_W)-1:0]          dev_sel,
  output logic                          dev_wr,
  output logic                          dev_rd,
  output logic [ADDR_W-1:0]             dev_addr,
  output logic [DATA_W/8-1:0]           dev_be,
  output logic [DATA_W-1:0]             dev_wdata,
  input  logic [(2**CS_W)*DATA_W-1:0]   dev_rdata
);

  localparam int NR = 2**CS_W;
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam bit NO_DWORD = (DATA_W == 32);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [CS_W-1:0]     cs_q;
  logic [OFF_W-1:0]    off_q;
  logic [1:0]          size_q;
  logic                wr_q;

  logic                misalign;
  logic                acc_err;
  logic [NR-1:0]       sel_hot;
  logic [OFF_W-1:0]    off_in;
  logic [LANES-1:0]    be_val;
  logic [DATA_W-1:0]   wd_val;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_val;
  logic [3:0]          wait_in;

  function automatic logic [LANES-1:0] lane_mask(
    input logic [1:0] s
  );
    case (s)
      2'd0:    return LANES'(8'h01);
      2'd1:    return LANES'(8'h03);
      2'd2:    return LANES'(8'h0F);
      default: return LANES'(8'hFF);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] data_mask(
    input logic [1:0] s
  );
    case (s)
      2'd0:    return DATA_W'(64'hFF);
      2'd1:    return DATA_W'(64'hFFFF);
      2'd2:    return DATA_W'(64'hFFFF_FFFF);
      default: return '1;
    endcase
  endfunction

  assign off_in  = req_addr[OFF_W-1:0];
  assign wait_in = WAIT_CYCLES[{req_cs, 2'b00} +: 4];

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      2'd3:    misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
    acc_err = !REGION_EN[req_cs] || misalign ||
              (req_size == 2'd3 && NO_DWORD);
    sel_hot = '0;
    sel_hot[req_cs] = 1'b1;
    be_val  = lane_mask(req_size) << off_in;
    wd_val  = req_wdata << {off_in, 3'b000};
    rd_word = dev_rdata[int'(cs_q)*DATA_W +: DATA_W];
    rd_val  = (rd_word >> {off_q, 3'b000}) & data_mask(size_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      dev_sel   <= '0;
      dev_wr    <= 1'b0;
      dev_rd    <= 1'b0;
      dev_addr  <= '0;
      dev_be    <= '0;
      dev_wdata <= '0;
      cnt       <= '0;
      cs_q      <= '0;
      off_q     <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            cs_q      <= req_cs;
            off_q     <= off_in;
            size_q    <= req_size;
            wr_q      <= req_write;
            if (acc_err) begin
              // Rejected requests never touch a device.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ACCESS;
              cnt       <= wait_in;
              dev_sel   <= sel_hot;
              dev_wr    <= req_write;
              dev_rd    <= !req_write;
              dev_addr  <= {req_addr[ADDR_W-1:OFF_W],
                            {OFF_W{1'b0}}};
              dev_be    <= be_val;
              dev_wdata <= wd_val;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            dev_sel   <= '0;
            dev_wr    <= 1'b0;
            dev_rd    <= 1'b0;
            dev_addr  <= '0;
            dev_be    <= '0;
            dev_wdata <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wr_q ? '0 : rd_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: expected responses are queued
// at accept and matched against each rsp_valid strobe.
module tb_mem_bus_ctrl;

  logic         clock;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [1:0]   req_cs;
  logic [31:0]  req_addr;
  logic [1:0]   req_size;
  logic [63:0]  req_wdata;
  logic         rsp_valid;
  logic         rsp_err;
  logic [63:0]  rsp_rdata;
  logic [3:0]   dev_sel;
  logic         dev_wr;
  logic         dev_rd;
  logic [31:0]  dev_addr;
  logic [7:0]   dev_be;
  logic [63:0]  dev_wdata;
  logic [255:0] dev_rdata;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   failures;

  mem_bus_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_cs    (req_cs),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .dev_sel   (dev_sel),
    .dev_wr    (dev_wr),
    .dev_rd    (dev_rd),
    .dev_addr  (dev_addr),
    .dev_be    (dev_be),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] cs,
                       input logic [31:0] addr,
                       input logic [1:0] sz,
                       input logic [63:0] wd,
                       input logic e, input logic [63:0] rd,
                       input int lat, input bit hold,
                       output int acc);
    int  i;
    bit  done;
    exp_t x;
    req_write = w;
    req_cs    = cs;
    req_addr  = addr;
    req_size  = sz;
    req_wdata = wd;
    req_valid = 1'b1;
    acc  = -1;
    done = 1'b0;
    i    = 0;
    while (!done && i < 40) begin
      if (req_ready) begin
        @(posedge clock);
        #1;
        acc  = cyc;
        done = 1'b1;
      end else begin
        @(negedge clock);
        i++;
      end
    end
    if (!done) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      x.err   = e;
      x.rdata = rd;
      x.acc   = acc;
      x.lat   = lat;
      sb.push_back(x);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  int          a1, a2, a3, n, off;
  logic [63:0] d2, m, exp_rd;
  logic [15:0] t;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_cs    = '0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    dev_rdata = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_dev_sel", {60'd0, dev_sel}, 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_be", {56'd0, dev_be}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // reset in the middle of a region-3 access
    issue(1'b0, 2'd3, 32'h0, 2'd3, 64'd0, 1'b0, 64'd0, 4, 0, a1);
    @(negedge clock);
    check("mid_sel", {60'd0, dev_sel}, 64'h8);
    check("mid_rd", {63'd0, dev_rd}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_sel", {60'd0, dev_sel}, 64'd0);
    check("rst_async_rd", {63'd0, dev_rd}, 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);

    // dword read, region 1, no wait
    dev_rdata[64 +: 64] = 64'h1122334455667788;
    issue(1'b0, 2'd1, 32'h10, 2'd3, 64'd0,
          1'b0, 64'h1122334455667788, 2, 0, a1);
    repeat (3) @(negedge clock);

    // byte write to lane 3
    issue(1'b1, 2'd1, 32'h13, 2'd0, 64'hAB,
          1'b0, 64'd0, 2, 0, a1);
    @(negedge clock);
    check("wr_be", {56'd0, dev_be}, 64'h08);
    check("wr_lane", {56'd0, dev_wdata[31:24]}, 64'hAB);
    check("wr_addr", {32'd0, dev_addr}, 64'h10);
    check("wr_strobe", {63'd0, dev_wr}, 64'd1);
    @(negedge clock);
    check("wr_strobe_off", {63'd0, dev_wr}, 64'd0);
    repeat (2) @(negedge clock);

    // half read with two wait states
    dev_rdata[192 +: 64] = 64'hBEEF_0000_0000_0000;
    issue(1'b0, 2'd3, 32'h06, 2'd1, 64'd0,
          1'b0, 64'h0000_0000_0000_BEEF, 4, 0, a1);
    n = 0;
    repeat (6) begin
      @(negedge clock);
      if (dev_rd) n++;
    end
    check("rd_hold", 64'(n), 64'd3);

    // disabled region and misaligned word
    issue(1'b0, 2'd0, 32'h0, 2'd2, 64'd0, 1'b1, 64'd0, 1, 0, a1);
    @(negedge clock);
    check("err_sel_cs0", {60'd0, dev_sel}, 64'd0);
    issue(1'b0, 2'd1, 32'h02, 2'd2, 64'd0, 1'b1, 64'd0, 1, 0, a1);
    @(negedge clock);
    check("err_sel_mis", {60'd0, dev_sel}, 64'd0);
    repeat (2) @(negedge clock);

    // size/offset sweep on region 2 (one wait state)
    d2 = 64'h8877_6655_4433_2211;
    dev_rdata[128 +: 64] = d2;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 2; k++) begin
        off = (k == 1) ? 8 - (1 << s) : 0;
        m = (s == 3) ? '1 : ((64'd1 << (8 << s)) - 64'd1);
        exp_rd = (d2 >> (8 * off)) & m;
        t = ((16'd1 << (1 << s)) - 16'd1) << off;
        issue(1'b0, 2'd2, 32'h40 + 32'(off), 2'(s), 64'd0,
              1'b0, exp_rd, 3, 0, a1);
        @(negedge clock);
        check("sweep_be", {56'd0, dev_be}, {48'd0, t});
        check("sweep_addr", {32'd0, dev_addr}, 64'h40);
      end
    end
    repeat (4) @(negedge clock);

    // req_valid held high across three requests
    dev_rdata[128 +: 64] = 64'hCAFE_F00D_1234_5678;
    issue(1'b0, 2'd2, 32'h8, 2'd2, 64'd0,
          1'b0, 64'h1234_5678, 3, 1, a1);
    issue(1'b1, 2'd1, 32'h20, 2'd0, 64'h5A,
          1'b0, 64'd0, 2, 1, a2);
    issue(1'b0, 2'd3, 32'h7, 2'd0, 64'd0,
          1'b0, 64'hBE, 4, 0, a3);
    check("b2b_gap1", 64'(a2 - a1), 64'd4);
    check("b2b_gap2", 64'(a3 - a2), 64'd3);

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
